// File: rtl/alu3_sweep_ctrl.sv
// rtl/alu3_sweep_ctrl.sv - sequencer that sweeps a small ALU through its enabled ops
//
// Purpose:
//   Latches one operand pair on start, steps the external combinational ALU
//   through every operation enabled in OP_MASK (one op per clock), captures
//   each result and its zero flag, then pulses done with all results stable.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   start, a_in, b_in    sweep request and operands, sampled only in IDLE
//   alu_din0, alu_din1   latched operands driven to the ALU
//   alu_sel              current ALU operation
//   alu_dout             combinational ALU result for the current drive
//   busy                 sweep in progress (RUN or DONE)
//   done                 one-cycle pulse, results valid and stable
//   res_add..res_shr     captured results of ops 0..3
//   zero_mask            bit k set when the op-k result is zero
module alu3_sweep_ctrl #(
  parameter int unsigned WIDTH   = 3,
  parameter logic [3:0]  OP_MASK = 4'b1111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] alu_din0,
  output logic [WIDTH-1:0] alu_din1,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_dout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_add,
  output logic [WIDTH-1:0] res_sub,
  output logic [WIDTH-1:0] res_and,
  output logic [WIDTH-1:0] res_shr,
  output logic [3:0]       zero_mask
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [1:0] lowest_op(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (m[2'(k)]) r = 2'(k);
    end
    return r;
  endfunction

  function automatic logic [1:0] highest_op(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 0; k <= 3; k++) begin
      if (m[2'(k)]) r = 2'(k);
    end
    return r;
  endfunction

  localparam logic [1:0] FIRST_OP = lowest_op(OP_MASK);
  localparam logic [1:0] LAST_OP  = highest_op(OP_MASK);
  localparam bit         NO_OPS   = (OP_MASK == 4'b0000);

  logic [1:0]       state;
  logic [1:0]       next_sel;
  logic [WIDTH-1:0] res_q [4];

  // Next higher enabled op above the current one; scanning downward leaves
  // the lowest qualifying op as the final assignment.
  always_comb begin
    next_sel = alu_sel;
    for (int k = 3; k >= 0; k--) begin
      if (OP_MASK[2'(k)] && (k > int'(alu_sel))) next_sel = 2'(k);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      alu_din0  <= '0;
      alu_din1  <= '0;
      alu_sel   <= 2'd0;
      zero_mask <= 4'b0000;
      for (int k = 0; k < 4; k++) res_q[k] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            alu_din0  <= a_in;
            alu_din1  <= b_in;
            alu_sel   <= FIRST_OP;
            zero_mask <= 4'b0000;
            for (int k = 0; k < 4; k++) res_q[k] <= '0;
            busy      <= 1'b1;
            // With nothing enabled the sweep collapses straight to its done cycle.
            if (NO_OPS) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          res_q[alu_sel]     <= alu_dout;
          zero_mask[alu_sel] <= (alu_dout == '0);
          if (alu_sel == LAST_OP) begin
            // alu_sel stays on the last op and is held through IDLE.
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            alu_sel <= next_sel;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign res_add = res_q[0];
  assign res_sub = res_q[1];
  assign res_and = res_q[2];
  assign res_shr = res_q[3];

endmodule

// File: tb/tb_alu3_sweep_ctrl.sv
// tb/tb_alu3_sweep_ctrl.sv - randomized self-checking bench for alu3_sweep_ctrl
module tb_alu3_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] a_in = 3'd0;
  logic [2:0] b_in = 3'd0;

  // Instance 0 has every op enabled, instance 1 only ops 0 and 2.
  logic [2:0] din0 [2];
  logic [2:0] din1 [2];
  logic [1:0] sel  [2];
  logic [2:0] dout [2];
  logic       busy [2];
  logic       done [2];
  logic [2:0] r_add [2];
  logic [2:0] r_sub [2];
  logic [2:0] r_and [2];
  logic [2:0] r_shr [2];
  logic [3:0] zm   [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  function automatic logic [2:0] alu_f(input logic [2:0] x, input logic [2:0] y, input logic [1:0] s);
    case (s)
      2'd0:    return x + y;
      2'd1:    return x - y;
      2'd2:    return x & y;
      default: return x >> 1;
    endcase
  endfunction

  assign dout[0] = alu_f(din0[0], din1[0], sel[0]);
  assign dout[1] = alu_f(din0[1], din1[1], sel[1]);

  alu3_sweep_ctrl #(.WIDTH(3), .OP_MASK(4'b1111)) u_dut_full (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .alu_din0(din0[0]), .alu_din1(din1[0]), .alu_sel(sel[0]), .alu_dout(dout[0]),
    .busy(busy[0]), .done(done[0]),
    .res_add(r_add[0]), .res_sub(r_sub[0]), .res_and(r_and[0]), .res_shr(r_shr[0]),
    .zero_mask(zm[0])
  );

  alu3_sweep_ctrl #(.WIDTH(3), .OP_MASK(4'b0101)) u_dut_part (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .alu_din0(din0[1]), .alu_din1(din1[1]), .alu_sel(sel[1]), .alu_dout(dout[1]),
    .busy(busy[1]), .done(done[1]),
    .res_add(r_add[1]), .res_sub(r_sub[1]), .res_and(r_and[1]), .res_shr(r_shr[1]),
    .zero_mask(zm[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: results straight from the operation definitions.
  function automatic logic [3:0] mask_of(input int i);
    return (i == 0) ? 4'b1111 : 4'b0101;
  endfunction

  function automatic logic [2:0] exp_res(input int a, input int b, input int k, input logic [3:0] m);
    int v;
    if (!m[k[1:0]]) return 3'd0;
    case (k)
      0:       v = (a + b) % 8;
      1:       v = (a + 8 - b) % 8;
      2:       v = a & b;
      default: v = a / 2;
    endcase
    return 3'(v);
  endfunction

  function automatic logic [3:0] exp_zm(input int a, input int b, input logic [3:0] m);
    logic [3:0] z;
    z = 4'b0000;
    for (int k = 0; k < 4; k++) z[k] = m[k] && (exp_res(a, b, k, m) == 3'd0);
    return z;
  endfunction

  function automatic int nth_op(input logic [3:0] m, input int n);
    int seen;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (m[k]) begin
        if (seen == n) return k;
        seen++;
      end
    end
    return 0;
  endfunction

  task automatic check_results(input int i, input int a, input int b);
    logic [3:0] m;
    m = mask_of(i);
    check($sformatf("res_add%0d", i), r_add[i], exp_res(a, b, 0, m));
    check($sformatf("res_sub%0d", i), r_sub[i], exp_res(a, b, 1, m));
    check($sformatf("res_and%0d", i), r_and[i], exp_res(a, b, 2, m));
    check($sformatf("res_shr%0d", i), r_shr[i], exp_res(a, b, 3, m));
    check($sformatf("zero_mask%0d", i), zm[i], exp_zm(a, b, m));
  endtask

  task automatic check_reset(input int i, input string tag);
    check($sformatf("%s_busy%0d", tag, i), busy[i], 0);
    check($sformatf("%s_done%0d", tag, i), done[i], 0);
    check($sformatf("%s_din0_%0d", tag, i), din0[i], 0);
    check($sformatf("%s_din1_%0d", tag, i), din1[i], 0);
    check($sformatf("%s_sel%0d", tag, i), sel[i], 0);
    check($sformatf("%s_res%0d", tag, i), {r_add[i], r_sub[i], r_and[i], r_shr[i]}, 0);
    check($sformatf("%s_zm%0d", tag, i), zm[i], 0);
  endtask

  task automatic do_sweep(input logic [2:0] a, input logic [2:0] b, input bit scramble);
    int done_at [2];
    bit fin [2];
    done_at[0] = 0; done_at[1] = 0;
    fin[0] = 1'b0;  fin[1] = 1'b0;
    @(negedge clk);
    a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!fin[i]) begin
          check($sformatf("busy%0d_c%0d", i, c), busy[i], 1);
          check($sformatf("din0_%0d", i), din0[i], a);
          check($sformatf("din1_%0d", i), din1[i], b);
          if (done[i]) begin
            fin[i] = 1'b1;
            done_at[i] = c;
            check_results(i, a, b);
          end else begin
            check($sformatf("sel%0d_c%0d", i, c), sel[i], nth_op(mask_of(i), c - 1));
          end
        end
      end
      if (fin[0] && fin[1]) break;
      if (scramble) begin
        a_in = 3'($urandom);
        b_in = 3'($urandom);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 2; i++)
      check($sformatf("done_lat%0d", i), done_at[i], $countones(mask_of(i)) + 1);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("idle_busy%0d", i), busy[i], 0);
      check($sformatf("idle_done%0d", i), done[i], 0);
      check_results(i, a, b);
    end
  endtask

  task automatic held_start(input logic [2:0] a, input logic [2:0] b);
    int n_done = 0;
    int first_done = -1;
    int restart = -1;
    @(negedge clk);
    a_in = a; b_in = b; start = 1'b1;
    for (int c = 0; c < 26; c++) begin
      @(posedge clk); #1;
      if (c == 9) start = 1'b0;
      if (done[0]) begin
        n_done++;
        check_results(0, a, b);
        if (first_done < 0) first_done = c;
      end
      if (first_done >= 0 && restart < 0 && c > first_done && busy[0]) restart = c;
    end
    check("held_sweeps", n_done, 2);
    check("held_first_done", first_done, 4);
    check("held_gap", restart - first_done, 2);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    for (int i = 0; i < 2; i++) check_reset(i, "por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_sweep(3'd5, 3'd3, 1'b0);
    do_sweep(3'd0, 3'd0, 1'b0);
    do_sweep(3'd6, 3'd3, 1'b0);
    held_start(3'd7, 3'd1);

    // Reset in the second RUN cycle of a sweep.
    @(negedge clk);
    a_in = 3'd1; b_in = 3'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("mid_res_add", r_add[0], 3);
    check("mid_sel", sel[0], 1);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) check_reset(i, "mid");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_no_done", done[0], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    do_sweep(3'd2, 3'd5, 1'b1);

    for (int n = 0; n < 10; n++) do_sweep(3'($urandom), 3'($urandom), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu3_sweep_ctrl.md
Name: alu3_sweep_ctrl

Overview:
- Sequencer that sits directly upstream of the team's 3-bit four-function combinational ALU (sel 0 add, 1 subtract, 2 AND, 3 logical shift-right of din0 by one).
- On a start request it latches one operand pair, drives the ALU through every enabled operation one per cycle, and captures each ALU result.
- It then presents all results and a per-operation zero mask to downstream logic, with a busy/done handshake.

Parameters:
- WIDTH, 3, operand/result width; must equal the ALU data width.
- OP_MASK, 4'b1111, bit k enables ALU op k (sel = k); disabled ops are skipped.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a sweep; sampled only in IDLE
- a_in  input  WIDTH  operand A, sampled with start
- b_in  input  WIDTH  operand B, sampled with start
- alu_din0  output  WIDTH  to ALU din0 (latched A)
- alu_din1  output  WIDTH  to ALU din1 (latched B)
- alu_sel  output  2  to ALU sel (current op)
- alu_dout  input  WIDTH  combinational ALU result for current alu_din0/alu_din1/alu_sel
- busy  output  1  high while sweep in progress (RUN or DONE)
- done  output  1  one-cycle pulse: results valid and stable
- res_add  output  WIDTH  captured op-0 result
- res_sub  output  WIDTH  captured op-1 result
- res_and  output  WIDTH  captured op-2 result
- res_shr  output  WIDTH  captured op-3 result
- zero_mask  output  4  bit k = 1 when op-k result is 0

Behaviour:
- Reset (async, immediate): state IDLE; busy=0, done=0; alu_din0/alu_din1=0; alu_sel=0; all res_*=0; zero_mask=0.
- All outputs are registered; the only combinational path is alu_dout sampled at the clock edge.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0: latch a_in/b_in into alu_din0/alu_din1.
  - Clear all res_* and zero_mask to 0.
  - Set alu_sel to the lowest enabled op.
  - Go to RUN, or to DONE if OP_MASK==0.
  - start=0: hold state and all outputs.
- RUN, each edge:
  - res[alu_sel] <= alu_dout; zero_mask[alu_sel] <= (alu_dout==0).
  - alu_sel advances to the next higher enabled op.
  - After the highest enabled op is captured, go to DONE.
- DONE: done=1 for exactly one cycle, busy=1; next edge returns to IDLE with busy=0 and done=0.
- Latency, with N = number of enabled ops:
  - RUN occupies edges E1..EN.
  - done is high in the cycle following EN.
  - busy is high from the cycle after E0 through the done cycle: N+1 cycles.
- Disabled ops: result and zero_mask bit stay 0 for that sweep.
- start while busy: ignored, no queuing. start in the DONE cycle: also ignored.
- alu_din0/alu_din1 do not change during a sweep, even if a_in/b_in change.
- Results and zero_mask hold after done until the next accepted start.
- alu_sel holds its last value in IDLE.
- Arithmetic belongs to the ALU: results are modulo 2^WIDTH, with no carry/borrow capture.
- Reset mid-sweep: immediate return to reset values; partial results are discarded; no done pulse.

Test Plan:
- a=5, b=3, start 1 cycle, OP_MASK=1111 -> busy 5 cycles; done pulses at the 5th busy cycle; res_add=0, res_sub=2, res_and=1, res_shr=2; zero_mask=4'b0001; alu_sel sequence 0,1,2,3.
- a=0, b=0 -> all res_*=0; zero_mask=4'b1111; done 5 cycles after start edge.
- a=7, b=1, start held high 10 cycles -> exactly two sweeps, separated by one IDLE cycle. Each sweep gives res_add=0, res_sub=6, res_and=1, res_shr=3; start during busy/DONE is not accepted.
- OP_MASK=4'b0101, a=6, b=3 -> alu_sel 0 then 2; busy 3 cycles; res_add=1, res_and=2, res_sub=0, res_shr=0; zero_mask=4'b0000.
- Assert rst during the 2nd RUN cycle -> all outputs 0 immediately (before the next clock edge); no done; a new start afterwards completes normally.
- Change a_in/b_in every cycle during a sweep -> alu_din0/alu_din1 and all results reflect only the values sampled with start.
